reg_writeback: RTL

Write-side controller for the 32×32 register file: merges the main pipeline's writeback with results from a long-latency unit (loads, mul/div) into the register file's single write port. Pending long-latency results sit in a 2-entry buffer. A pending-register scoreboard flags operands whose long-latency result has not yet been written, and decode uses those flags for stalling. Sits between the EX/MEM/WB pipeline, the long-latency unit and the register file write port.

---
 rtl/reg_writeback_pkg.sv | 12 +
 rtl/reg_writeback_wb_fifo.sv | 49 ++++
 rtl/reg_writeback.sv | 98 +++++++++
 3 files changed

// File: rtl/reg_writeback_pkg.sv
// Shared types and widths for the register-file write-side controller.
package reg_writeback_pkg;
  localparam int REG_AW = 5;
  localparam int DATA_W = 32;
  localparam int DEPTH  = 2;
  localparam logic [REG_AW-1:0] REG_ZERO = 5'd0;

  typedef struct packed {
    logic [REG_AW-1:0] addr;
    logic [DATA_W-1:0] data;
  } wb_entry_t;
endpackage

// File: rtl/reg_writeback_wb_fifo.sv
// Two-entry first-word-fall-through buffer of writeback entries.
module wb_fifo
  import reg_writeback_pkg::*;
(
  input  logic      clk,
  input  logic      rst_n,
  input  logic      push,
  input  wb_entry_t push_entry,
  input  logic      pop,
  output wb_entry_t head_entry,
  output logic [1:0] count,
  output logic      full
);
  wb_entry_t  mem_q [DEPTH];
  logic       wr_ptr_q;
  logic       rd_ptr_q;
  logic [1:0] count_q;
  logic       push_ok;
  logic       pop_ok;

  // Full blocks a push even when a pop frees a slot in the same cycle.
  assign full    = (count_q == 2'(DEPTH));
  assign push_ok = push && !full;
  assign pop_ok  = pop && (count_q != 2'd0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem_q[0] <= '0;
      mem_q[1] <= '0;
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
      count_q  <= 2'd0;
    end else begin
      if (push_ok) begin
        mem_q[wr_ptr_q] <= push_entry;
        wr_ptr_q        <= ~wr_ptr_q;
      end
      if (pop_ok) rd_ptr_q <= ~rd_ptr_q;
      case ({push_ok, pop_ok})
        2'b10:   count_q <= count_q + 2'd1;
        2'b01:   count_q <= count_q - 2'd1;
        default: count_q <= count_q;
      endcase
    end
  end

  assign head_entry = mem_q[rd_ptr_q];
  assign count      = count_q;
endmodule

// File: rtl/reg_writeback.sv
// Merges pipeline writeback and buffered long-latency results onto the
// single register-file write port, and tracks pending destinations.
module reg_writeback
  import reg_writeback_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              pipe_wr,
  input  logic [REG_AW-1:0] pipe_addr,
  input  logic [DATA_W-1:0] pipe_din,
  input  logic              lu_valid,
  output logic              lu_ready,
  input  logic [REG_AW-1:0] lu_addr,
  input  logic [DATA_W-1:0] lu_din,
  input  logic              issue_valid,
  input  logic [REG_AW-1:0] issue_addr,
  input  logic [REG_AW-1:0] q1_addr,
  input  logic [REG_AW-1:0] q2_addr,
  output logic              q1_busy,
  output logic              q2_busy,
  output logic              r3_wr,
  output logic [REG_AW-1:0] r3_addr,
  output logic [DATA_W-1:0] r3_din,
  output logic [1:0]        count
);
  wb_entry_t         head;
  wb_entry_t         lu_entry;
  logic              fifo_full;
  logic              pipe_eff;
  logic              lu_push;
  logic              head_pop;
  logic              head_sel;
  logic              r3_wr_q, r3_wr_d;
  logic [REG_AW-1:0] r3_addr_q, r3_addr_d;
  logic [DATA_W-1:0] r3_din_q, r3_din_d;
  logic [31:0]       pending_q, pending_d;

  assign pipe_eff = pipe_wr && (pipe_addr != REG_ZERO);
  assign lu_ready = !fifo_full;
  assign lu_push  = lu_valid && lu_ready;
  assign head_pop = !pipe_eff && (count != 2'd0);
  // Address-0 entries still drain, they just never reach the write port.
  assign head_sel = head_pop && (head.addr != REG_ZERO);
  assign lu_entry = '{addr: lu_addr, data: lu_din};

  wb_fifo u_fifo (
    .clk        (clk),
    .rst_n      (rst_n),
    .push       (lu_push),
    .push_entry (lu_entry),
    .pop        (head_pop),
    .head_entry (head),
    .count      (count),
    .full       (fifo_full)
  );

  always_comb begin
    r3_wr_d   = 1'b0;
    r3_addr_d = r3_addr_q;
    r3_din_d  = r3_din_q;
    if (pipe_eff) begin
      r3_wr_d   = 1'b1;
      r3_addr_d = pipe_addr;
      r3_din_d  = pipe_din;
    end else if (head_sel) begin
      r3_wr_d   = 1'b1;
      r3_addr_d = head.addr;
      r3_din_d  = head.data;
    end
  end

  // Set after clear so a re-issue on the retiring edge keeps the bit.
  always_comb begin
    pending_d = pending_q;
    if (head_sel) pending_d[head.addr] = 1'b0;
    if (issue_valid && (issue_addr != REG_ZERO)) pending_d[issue_addr] = 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r3_wr_q   <= 1'b0;
      r3_addr_q <= REG_ZERO;
      r3_din_q  <= '0;
      pending_q <= '0;
    end else begin
      r3_wr_q   <= r3_wr_d;
      r3_addr_q <= r3_addr_d;
      r3_din_q  <= r3_din_d;
      pending_q <= pending_d;
    end
  end

  assign q1_busy = (q1_addr != REG_ZERO) && pending_q[q1_addr];
  assign q2_busy = (q2_addr != REG_ZERO) && pending_q[q2_addr];
  assign r3_wr   = r3_wr_q;
  assign r3_addr = r3_addr_q;
  assign r3_din  = r3_din_q;
endmodule
